// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//   Bundles the parallel-side request signals and the serial-side outputs of
//   the UART transmitter so they travel as one port.
//
//   Signals
//     P_DATA      [DATA_WIDTH-1:0]  parallel word to send
//     Data_Valid  1                 request to transmit P_DATA
//     PAR_EN      1                 1 = append a parity bit
//     PAR_TYP     1                 parity type, 0 = even, 1 = odd
//     TX_OUT      1                 registered serial line, idles high
//     Busy        1                 registered, high while a frame is on the line
//
//   Modports
//     master  drives the request side, observes the line (producer / bench)
//     slave   the transmitter itself
// ---------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serial transmitter, one bit per CLK cycle. Frame: start bit 0, DATA_WIDTH
//   data bits LSB first, optional parity bit, stop bit 1. A request seen
//   while the stop bit is on the line starts the next frame straight away,
//   so consecutive words go out with no idle bit between them.
//
//   Ports
//     CLK   input   bit clock (one period = one bit time)
//     RST   input   asynchronous reset, active low
//     bus   uart_tx_if.slave  P_DATA / Data_Valid / PAR_EN / PAR_TYP in,
//                             TX_OUT / Busy out (both registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                stateQ,   stateD;
    logic [DATA_WIDTH-1:0] dataQ,    dataD;
    logic                  parEnQ,   parEnD;
    logic                  parTypQ,  parTypD;
    logic [CNT_W-1:0]      bitCntQ,  bitCntD;
    logic                  txQ,      txD;
    logic                  busyQ,    busyD;

    logic                  accept;
    logic                  lastBit;
    logic [CNT_W-1:0]      nextCnt;
    logic                  parityBit;

    // A new word is only taken when the line is idle or about to finish the
    // stop bit; everywhere else Data_Valid is ignored.
    assign accept    = bus.Data_Valid && ((stateQ == IDLE) || (stateQ == STOP));
    assign lastBit   = (bitCntQ == CNT_W'(DATA_WIDTH - 1));
    assign nextCnt   = bitCntQ + 1'b1;
    // Parity comes from the captured word so mid-frame input changes are harmless.
    assign parityBit = (^dataQ) ^ parTypQ;

    // State and output registers. TX_OUT and Busy are registered so the line
    // is glitch-free; the next-state logic therefore computes the value each
    // one must take for the state being entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateQ  <= IDLE;
            dataQ   <= '0;
            parEnQ  <= 1'b0;
            parTypQ <= 1'b0;
            bitCntQ <= '0;
            txQ     <= 1'b1;
            busyQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            dataQ   <= dataD;
            parEnQ  <= parEnD;
            parTypQ <= parTypD;
            bitCntQ <= bitCntD;
            txQ     <= txD;
            busyQ   <= busyD;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        stateD  = stateQ;
        dataD   = dataQ;
        parEnD  = parEnQ;
        parTypD = parTypQ;
        bitCntD = bitCntQ;
        txD     = 1'b1;
        busyD   = 1'b0;

        if (accept) begin
            dataD   = bus.P_DATA;
            parEnD  = bus.PAR_EN;
            parTypD = bus.PAR_TYP;
        end

        case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateD = START;
                    txD    = 1'b0;
                    busyD  = 1'b1;
                end
            end
            START: begin
                stateD  = DATA;
                bitCntD = '0;
                txD     = dataQ[0];
                busyD   = 1'b1;
            end
            DATA: begin
                busyD = 1'b1;
                if (lastBit) begin
                    if (parEnQ) begin
                        stateD = PARITY;
                        txD    = parityBit;
                    end else begin
                        stateD = STOP;
                        txD    = 1'b1;
                    end
                end else begin
                    bitCntD = nextCnt;
                    txD     = dataQ[nextCnt];
                end
            end
            PARITY: begin
                stateD = STOP;
                txD    = 1'b1;
                busyD  = 1'b1;
            end
            STOP: begin
                // Back-to-back: go straight to a new start bit, Busy stays high.
                if (accept) begin
                    stateD = START;
                    txD    = 1'b0;
                    busyD  = 1'b1;
                end else begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign bus.TX_OUT = txQ;
    assign bus.Busy   = busyQ;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx: reset state, plain and parity frames, parity
//   type, back-to-back frames, mid-frame input changes and mid-frame reset.
//   Line samples are taken on the falling clock edge; stimulus is driven
//   just after the rising edge or on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic CLK;
    logic RST;

    int testsRun;
    int testsFailed;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present a word and let it be accepted on the next rising edge. With
    // holdValid the request stays asserted after the accept edge.
    task automatic startFrame(input logic [7:0] data, input logic parEn,
                              input logic parTyp, input logic holdValid);
        @(negedge CLK);
        bus.P_DATA     = data;
        bus.PAR_EN     = parEn;
        bus.PAR_TYP    = parTyp;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        if (!holdValid) bus.Data_Valid = 1'b0;
    endtask

    // Record n consecutive falling-edge samples; the first sample ends up as
    // the most significant of the n low bits.
    task automatic captureLine(input int n, output logic [31:0] txSeen,
                               output logic [31:0] busySeen);
        txSeen   = '0;
        busySeen = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            txSeen   = {txSeen[30:0],   bus.TX_OUT};
            busySeen = {busySeen[30:0], bus.Busy};
        end
    endtask

    task automatic test_reset();
        RST            = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        #12;
        testsRun++;
        if (bus.TX_OUT !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_tx: got %b, expected 1", bus.TX_OUT);
        end
        testsRun++;
        if (bus.Busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", bus.Busy);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        testsRun++;
        if ({bus.TX_OUT, bus.Busy} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset: got tx/busy %b, expected 10",
                     {bus.TX_OUT, bus.Busy});
        end
    endtask

    task automatic test_no_parity();
        logic [31:0] txSeen, busySeen;
        startFrame(8'hA5, 1'b0, 1'b0, 1'b0);
        captureLine(11, txSeen, busySeen);
        testsRun++;
        if (txSeen !== 32'b0_10100101_1_1) begin
            testsFailed++;
            $display("[TB] FAIL a5_nopar_tx: got %b, expected %b", txSeen, 32'b0_10100101_1_1);
        end
        testsRun++;
        if (busySeen !== 32'b1111111111_0) begin
            testsFailed++;
            $display("[TB] FAIL a5_nopar_busy: got %b, expected %b", busySeen, 32'b1111111111_0);
        end
    endtask

    task automatic test_parity();
        logic [31:0] txSeen, busySeen;
        logic [7:0]  words   [4] = '{8'hA5, 8'hA5, 8'h07, 8'h07};
        logic        types   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] expTx   [4] = '{32'b0_10100101_0_1_1, 32'b0_10100101_1_1_1,
                                     32'b0_11100000_1_1_1, 32'b0_11100000_0_1_1};
        for (int k = 0; k < 4; k++) begin
            startFrame(words[k], 1'b1, types[k], 1'b0);
            captureLine(12, txSeen, busySeen);
            testsRun++;
            if (txSeen !== expTx[k]) begin
                testsFailed++;
                $display("[TB] FAIL parity_tx[%0d] data=%h typ=%b: got %b, expected %b",
                         k, words[k], types[k], txSeen, expTx[k]);
            end
            testsRun++;
            if (busySeen !== 32'b11111111111_0) begin
                testsFailed++;
                $display("[TB] FAIL parity_busy[%0d]: got %b, expected %b",
                         k, busySeen, 32'b11111111111_0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] txSeen, busySeen;
        txSeen   = '0;
        busySeen = '0;
        startFrame(8'h3C, 1'b0, 1'b0, 1'b1);
        bus.P_DATA = 8'hC3;
        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            txSeen   = {txSeen[30:0],   bus.TX_OUT};
            busySeen = {busySeen[30:0], bus.Busy};
            if (i == 10) bus.Data_Valid = 1'b0;
        end
        testsRun++;
        if (txSeen !== 32'b0_00111100_1_0_11000011_1_1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_tx: got %b, expected %b",
                     txSeen, 32'b0_00111100_1_0_11000011_1_1);
        end
        testsRun++;
        if (busySeen !== 32'b11111111111111111111_0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_busy: got %b, expected %b",
                     busySeen, 32'b11111111111111111111_0);
        end
    endtask

    task automatic test_data_change();
        logic [31:0] txSeen, busySeen;
        txSeen   = '0;
        busySeen = '0;
        startFrame(8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            txSeen   = {txSeen[30:0],   bus.TX_OUT};
            busySeen = {busySeen[30:0], bus.Busy};
            if (i == 3) begin
                bus.P_DATA  = 8'hFF;
                bus.PAR_EN  = 1'b1;
                bus.PAR_TYP = 1'b1;
            end
        end
        testsRun++;
        if (txSeen !== 32'b0_10101010_1_1) begin
            testsFailed++;
            $display("[TB] FAIL change_tx: got %b, expected %b", txSeen, 32'b0_10101010_1_1);
        end
        testsRun++;
        if (busySeen !== 32'b1111111111_0) begin
            testsFailed++;
            $display("[TB] FAIL change_busy: got %b, expected %b", busySeen, 32'b1111111111_0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] txSeen, busySeen;
        startFrame(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        #1;
        testsRun++;
        if ({bus.TX_OUT, bus.Busy} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL midreset_immediate: got tx/busy %b, expected 10",
                     {bus.TX_OUT, bus.Busy});
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        testsRun++;
        if ({bus.TX_OUT, bus.Busy} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL midreset_no_resume: got tx/busy %b, expected 10",
                     {bus.TX_OUT, bus.Busy});
        end
        startFrame(8'h81, 1'b0, 1'b0, 1'b0);
        captureLine(11, txSeen, busySeen);
        testsRun++;
        if (txSeen !== 32'b0_10000001_1_1) begin
            testsFailed++;
            $display("[TB] FAIL after_reset_tx: got %b, expected %b", txSeen, 32'b0_10000001_1_1);
        end
        testsRun++;
        if (busySeen !== 32'b1111111111_0) begin
            testsFailed++;
            $display("[TB] FAIL after_reset_busy: got %b, expected %b", busySeen, 32'b1111111111_0);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
